alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Upstream driver of the ALU operand/control interface: the producer of A, B and ALUControl, and the consumer of ALU_Result and Zero.
- Accepts one decoded instruction per handshake on a valid/ready input channel.
- Decodes ALUOp/funct3/funct7b5/op_b5 into the 3-bit ALUControl code and drives registered operands to the combinational ALU.
- Captures ALU_Result/Zero one cycle later and returns them on a valid/ready output channel. Sits between decode and writeback/branch logic.

Parameters:
WIDTH, 32, datapath width of operands and result.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  upstream request valid.
in_ready  output  1  issuer can accept a request.
ALUOp  input  2  class: 00 load/store, 01 branch, 10 R/I arithmetic, 11 reserved.
funct3  input  3  instruction funct3.
funct7b5  input  1  instruction bit 30.
op_b5  input  1  opcode bit 5 (1 = R-type).
SrcA  input  WIDTH  operand A.
SrcB  input  WIDTH  operand B.
A  output  WIDTH  registered operand to ALU.
B  output  WIDTH  registered operand to ALU.
ALUControl  output  3  registered ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT.
ALU_Result  input  WIDTH  ALU result (combinational from A/B/ALUControl).
Zero  input  1  ALU zero flag.
out_valid  output  1  Result/ZeroOut/Illegal valid.
out_ready  input  1  downstream accepts response.
Result  output  WIDTH  captured ALU_Result.
ZeroOut  output  1  captured Zero.
Illegal  output  1  request had unsupported encoding.
OpCount  output  CNT_W  number of completed responses.

Behaviour:
- Single clock domain. Reset asserted (rst_n=0) is immediate and asynchronous.
- Values held while in reset: state IDLE, A=0, B=0, ALUControl=000, Result=0, ZeroOut=0, Illegal=0, out_valid=0, OpCount=0.
- Reset mid-operation: pending request and response are discarded; no partial output is produced.
- FSM states: IDLE, DRIVE, RESP.
- in_ready is combinational: 1 only in IDLE (base build).
- IDLE: on in_valid&in_ready at edge N, register SrcA→A, SrcB→B, decoded op→ALUControl, decode-error→illegal latch; go to DRIVE.
- DRIVE: exactly one cycle. At edge N+1: ALU_Result→Result, Zero→ZeroOut, illegal latch→Illegal, out_valid←1; go to RESP.
- Latency: 2 edges from accept to out_valid high.
- RESP: Result/ZeroOut/Illegal are held stable while out_valid=1 and out_ready=0. On out_valid&out_ready: out_valid←0, OpCount←OpCount+1 (wraps modulo 2^CNT_W), go to IDLE.
- A/B/ALUControl hold their last values outside DRIVE; they are not cleared on completion.
- Decode rules:
  - ALUOp 00 → ADD.
  - ALUOp 01 → SUB.
  - ALUOp 10 by funct3: 000 → SUB if funct7b5&op_b5, else ADD; 010 → SLT; 100 → XOR; 110 → OR; 111 → AND; 001/011/101 → ADD with Illegal=1.
  - ALUOp 11 → ADD with Illegal=1.
- Illegal requests still complete a full handshake and increment OpCount.
- in_valid while not in IDLE is ignored (no accept). Upstream holds the request.

Optional Feature:
ALU_OP_ISSUER_PIPE_EN
- Defined: in_ready = (state==IDLE) | (state==RESP & out_ready). A new request accepted in the same cycle as the response drain goes directly RESP→DRIVE, giving one response every 2 cycles under full throughput. OpCount still increments on that drain.
- Undefined: in_ready high only in IDLE, giving one response per 3 cycles minimum.

Test Plan:
- SrcA=0x0000000A, SrcB=0x00000005, ALUOp=00, out_ready=1 → ALUControl=000, out_valid 2 edges after accept, Result=0x0000000F, ZeroOut=0, OpCount=1.
- Same operands, ALUOp=10, funct3=000, funct7b5=1, op_b5=1 → ALUControl=001, Result=0x00000005. Repeat with op_b5=0 (I-type) → ALUControl=000, Result=0x0000000F.
- ALUOp=10, funct3=010, A=10, B=5 → ALUControl=101, Result=0, ZeroOut=1. Then funct3=111 → ALUControl=010, Result=0x00000000; funct3=110 → 011, Result=0x0000000F; funct3=100 → 100, Result=0x0000000F.
- out_ready held 0 for 3 cycles in RESP → out_valid stays 1, Result stable, in_ready=0, a presented in_valid is not accepted. out_ready=1 → drain, IDLE, OpCount+1.
- ALUOp=10, funct3=001 → Illegal=1, ALUControl=000. ALUOp=11 → Illegal=1.
- rst_n pulsed low during DRIVE → out_valid=0, A=B=0, OpCount=0 immediately, without waiting for a clock edge. No response is emitted after release.
- With ALU_OP_ISSUER_PIPE_EN, 4 back-to-back requests with out_ready=1 → responses at 2-cycle spacing, OpCount=4.

Source files
------------

// File: rtl/alu_op_issuer.sv
// ALU operand/control issuer: accepts decoded requests, drives the ALU, returns results.
// Optional macro ALU_OP_ISSUER_PIPE_EN lets a new request be accepted while a response drains.
module alu_op_issuer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             op_b5,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic             Zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             ZeroOut,
    output logic             Illegal,
    output logic [CNT_W-1:0] OpCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         ctrl_q;
    logic               ill_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               illegal_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [2:0]         ctrl_d;
    logic               ill_d;
    logic               accept;
    logic               drain;

    always_comb begin
        ctrl_d = OP_ADD;
        ill_d  = 1'b0;
        case (ALUOp)
            2'b00: ctrl_d = OP_ADD;
            2'b01: ctrl_d = OP_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  ctrl_d = (funct7b5 & op_b5) ? OP_SUB : OP_ADD;
                    3'b010:  ctrl_d = OP_SLT;
                    3'b100:  ctrl_d = OP_XOR;
                    3'b110:  ctrl_d = OP_OR;
                    3'b111:  ctrl_d = OP_AND;
                    default: ill_d  = 1'b1;
                endcase
            end
            default: ill_d = 1'b1;
        endcase
    end

`ifdef ALU_OP_ISSUER_PIPE_EN
    assign in_ready = (state_q == IDLE) | ((state_q == RESP) & out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept = in_valid & in_ready;
    assign drain  = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= OP_ADD;
            ill_q       <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= SrcA;
                        b_q     <= SrcB;
                        ctrl_q  <= ctrl_d;
                        ill_q   <= ill_d;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    result_q    <= ALU_Result;
                    zero_q      <= Zero;
                    illegal_q   <= ill_q;
                    out_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (drain) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= cnt_q + 1'b1;
                        state_q     <= IDLE;
                        // Back-to-back: accept overlaps the drain edge.
                        if (accept) begin
                            a_q     <= SrcA;
                            b_q     <= SrcB;
                            ctrl_q  <= ctrl_d;
                            ill_q   <= ill_d;
                            state_q <= DRIVE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign ALUControl = ctrl_q;
    assign Result     = result_q;
    assign ZeroOut    = zero_q;
    assign Illegal    = illegal_q;
    assign out_valid  = out_valid_q;
    assign OpCount    = cnt_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: vector table, randomized ops vs reference model, reset and stall cases.
// Define ALU_OP_ISSUER_PIPE_EN to also exercise back-to-back issue.
module tb_alu_op_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        op_b5;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUControl;
    logic [31:0] ALU_Result;
    logic        Zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        ZeroOut;
    logic        Illegal;
    logic [15:0] OpCount;

    int passed = 0;
    int total  = 0;
    int cnt_model = 0;

    always #5 clk = ~clk;

    alu_op_issuer #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5), .op_b5(op_b5),
        .SrcA(SrcA), .SrcB(SrcB),
        .A(A), .B(B), .ALUControl(ALUControl),
        .ALU_Result(ALU_Result), .Zero(Zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .ZeroOut(ZeroOut), .Illegal(Illegal),
        .OpCount(OpCount)
    );

    // Combinational ALU sitting downstream of the issuer.
    always_comb begin
        ALU_Result = 32'h0;
        case (ALUControl)
            3'b000: ALU_Result = A + B;
            3'b001: ALU_Result = A - B;
            3'b010: ALU_Result = A & B;
            3'b011: ALU_Result = A | B;
            3'b100: ALU_Result = A ^ B;
            3'b101: ALU_Result = {31'h0, $signed(A) < $signed(B)};
            default: ALU_Result = 32'h0;
        endcase
        Zero = (ALU_Result == 32'h0);
    end

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic        f7;
        logic        opb5;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Instruction-level semantics: what the instruction means, not how it is encoded.
    function automatic vec_t model(input logic [1:0] aluop, input logic [2:0] f3,
                                   input logic f7, input logic opb5,
                                   input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.aluop = aluop; v.f3 = f3; v.f7 = f7; v.opb5 = opb5;
        v.a = a; v.b = b; v.ill = 1'b0;
        v.ctrl = 3'd0; v.res = a + b;
        if (aluop == 2'd1) begin
            v.ctrl = 3'd1; v.res = a - b;
        end else if (aluop == 2'd3) begin
            v.ill = 1'b1;
        end else if (aluop == 2'd2) begin
            if (f3 == 3'd0 && f7 && opb5) begin
                v.ctrl = 3'd1; v.res = a - b;
            end else if (f3 == 3'd2) begin
                v.ctrl = 3'd5; v.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end else if (f3 == 3'd4) begin
                v.ctrl = 3'd4; v.res = a ^ b;
            end else if (f3 == 3'd6) begin
                v.ctrl = 3'd3; v.res = a | b;
            end else if (f3 == 3'd7) begin
                v.ctrl = 3'd2; v.res = a & b;
            end else if (f3 != 3'd0) begin
                v.ill = 1'b1;
            end
        end
        v.zero = (v.res == 32'h0);
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        ALUOp = v.aluop; funct3 = v.f3; funct7b5 = v.f7; op_b5 = v.opb5;
        SrcA = v.a; SrcB = v.b;
    endtask

    task automatic run(input vec_t v, input int hold, input bit poke);
        @(negedge clk);
        drive_req(v);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("A", A, v.a);
        check("B", B, v.b);
        check("ALUControl", 32'(ALUControl), 32'(v.ctrl));
        check("out_valid_drive", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("out_valid_resp", 32'(out_valid), 32'd1);
        check("Result", Result, v.res);
        check("ZeroOut", 32'(ZeroOut), 32'(v.zero));
        check("Illegal", 32'(Illegal), 32'(v.ill));
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                in_valid = 1'b1;
                SrcA = ~v.a;
            end
            check("in_ready_stall", 32'(in_ready), 32'd0);
            @(negedge clk);
            check("out_valid_stall", 32'(out_valid), 32'd1);
            check("Result_stall", Result, v.res);
            check("A_no_accept", A, v.a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        cnt_model++;
        check("out_valid_drain", 32'(out_valid), 32'd0);
        check("OpCount", 32'(OpCount), 32'(cnt_model[15:0]));
    endtask

    vec_t tbl[12];
    vec_t v;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUOp = 2'd0; funct3 = 3'd0; funct7b5 = 1'b0; op_b5 = 1'b0;
        SrcA = 32'h0; SrcB = 32'h0;

        tbl[0]  = '{2'b00, 3'b000, 1'b0, 1'b0, 32'd10, 32'd5, 3'b000, 32'h0F, 1'b0, 1'b0};
        tbl[1]  = '{2'b10, 3'b000, 1'b1, 1'b1, 32'd10, 32'd5, 3'b001, 32'h05, 1'b0, 1'b0};
        tbl[2]  = '{2'b10, 3'b000, 1'b1, 1'b0, 32'd10, 32'd5, 3'b000, 32'h0F, 1'b0, 1'b0};
        tbl[3]  = '{2'b10, 3'b010, 1'b0, 1'b0, 32'd10, 32'd5, 3'b101, 32'h00, 1'b1, 1'b0};
        tbl[4]  = '{2'b10, 3'b111, 1'b0, 1'b0, 32'd10, 32'd5, 3'b010, 32'h00, 1'b1, 1'b0};
        tbl[5]  = '{2'b10, 3'b110, 1'b0, 1'b0, 32'd10, 32'd5, 3'b011, 32'h0F, 1'b0, 1'b0};
        tbl[6]  = '{2'b10, 3'b100, 1'b0, 1'b0, 32'd10, 32'd5, 3'b100, 32'h0F, 1'b0, 1'b0};
        tbl[7]  = '{2'b10, 3'b001, 1'b0, 1'b0, 32'd10, 32'd5, 3'b000, 32'h0F, 1'b0, 1'b1};
        tbl[8]  = '{2'b11, 3'b000, 1'b0, 1'b0, 32'd10, 32'd5, 3'b000, 32'h0F, 1'b0, 1'b1};
        tbl[9]  = '{2'b01, 3'b000, 1'b0, 1'b0, 32'd10, 32'd5, 3'b001, 32'h05, 1'b0, 1'b0};
        tbl[10] = '{2'b01, 3'b000, 1'b0, 1'b0, 32'd5,  32'd5, 3'b001, 32'h00, 1'b1, 1'b0};
        tbl[11] = '{2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 3'b101, 32'h01, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_A", A, 32'h0);
        check("rst_B", B, 32'h0);
        check("rst_ALUControl", 32'(ALUControl), 32'd0);
        check("rst_Result", Result, 32'h0);
        check("rst_Illegal", 32'(Illegal), 32'd0);
        check("rst_OpCount", 32'(OpCount), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        foreach (tbl[i]) run(tbl[i], 0, 1'b0);

        run(tbl[5], 3, 1'b1);

        for (int i = 0; i < 40; i++) begin
            v = model(2'($urandom_range(3)), 3'($urandom_range(7)),
                      1'($urandom_range(1)), 1'($urandom_range(1)),
                      ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom(),
                      ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom());
            run(v, $urandom_range(2), 1'($urandom_range(1)));
        end

        // Asynchronous reset while the request sits in DRIVE.
        @(negedge clk);
        drive_req(tbl[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cnt_model = 0;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_A", A, 32'h0);
        check("arst_B", B, 32'h0);
        check("arst_OpCount", 32'(OpCount), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_resp", 32'(out_valid), 32'd0);
        end

`ifdef ALU_OP_ISSUER_PIPE_EN
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(tbl[i + 3]);
            in_valid = 1'b1;
            check("pipe_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            if (i == 3) in_valid = 1'b0;
            @(negedge clk);
            check("pipe_drive_gap", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("pipe_out_valid", 32'(out_valid), 32'd1);
            check("pipe_Result", Result, tbl[i + 3].res);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pipe_OpCount", 32'(OpCount), 32'd4);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
